addsub_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one 8-bit adder/subtractor between two requesters. Each requester presents operands and an add/sub select with a request line. The block grants round-robin, latches the operands, computes in one cycle and returns a registered result with a per-requester done pulse. It sits between the ALU-style compute datapath and the client blocks that previously drove that datapath directly.

---
 rtl/addsub_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_addsub_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//    Shares one WIDTH-bit adder/subtractor between two requesters. Requests
//    are sampled only while idle; contention is resolved round-robin (the
//    pointer resets to "last = 1", so requester 0 wins the first tie). The
//    granted operands are latched, computed in one cycle, and returned as a
//    registered result with a done pulse for the owner.
//
//    Ports
//       clk            rising-edge clock
//       rst_n          synchronous active-low reset
//       req0/req1      level requests, held until the matching ack
//       a0,b0,a1,b1    operands per requester
//       mode0/mode1    0 = A+B, 1 = A-B
//       ack0/ack1      one-cycle pulse: operands latched
//       done0/done1    one-cycle pulse: result/carry valid for that requester
//       result,carry   registered sum/difference and MSB carry-out
//       busy           high while an operation is in flight
//       overflow       signed overflow, only when ADDSUB_ARB_OVF_EN is defined
//
//    Optional feature macro: ADDSUB_ARB_OVF_EN (adds port overflow).
//
//    Output timing relative to the grant edge N:
//       ack  cycle N, busy cycles N+1..N+2, done/result cycle N+2,
//       earliest next grant at edge N+3.
//    All outputs are registered, so busy and done lag the state register by
//    one edge; the FSM is back in IDLE while done is visible.

module addsub_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             mode0,
   input  logic             mode1,
   output logic             ack0,
   output logic             ack1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             carry,
`ifdef ADDSUB_ARB_OVF_EN
   output logic             overflow,
`endif
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             mode_q, mode_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic             done0_q, done0_d;
   logic             done1_q, done1_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             busy_q, busy_d;
`ifdef ADDSUB_ARB_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   // Shared datapath: subtraction is A + ~B + 1, so carry = 1 means no borrow.
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   sum_ext;
   logic             gnt1;

   always_comb begin
      b_eff   = mode_q ? ~b_q : b_q;
      sum_ext = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode_q};
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      mode_d   = mode_q;
      owner_d  = owner_q;
      last_d   = last_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      result_d = result_q;
      carry_d  = carry_q;
      busy_d   = (state_q != IDLE);
`ifdef ADDSUB_ARB_OVF_EN
      ovf_d    = ovf_q;
`endif
      // Requester 1 wins when it is alone, or when both ask and 0 went last.
      gnt1     = req1 && (!req0 || !last_q);

      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               a_d     = gnt1 ? a1 : a0;
               b_d     = gnt1 ? b1 : b0;
               mode_d  = gnt1 ? mode1 : mode0;
               ack0_d  = !gnt1;
               ack1_d  = gnt1;
               owner_d = gnt1;
               last_d  = gnt1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            result_d = sum_ext[WIDTH-1:0];
            carry_d  = sum_ext[WIDTH];
`ifdef ADDSUB_ARB_OVF_EN
            ovf_d    = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
`endif
            state_d  = RESP;
         end
         RESP: begin
            done0_d = !owner_q;
            done1_d = owner_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         mode_q   <= 1'b0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         mode_q   <= mode_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         busy_q   <= busy_d;
`ifdef ADDSUB_ARB_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign ack0   = ack0_q;
   assign ack1   = ack1_q;
   assign done0  = done0_q;
   assign done1  = done1_q;
   assign result = result_q;
   assign carry  = carry_q;
   assign busy   = busy_q;
`ifdef ADDSUB_ARB_OVF_EN
   assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter
//    Table of single operations, hand-written contention / reset sequences,
//    and a randomized phase checked against a transaction-level model.
//    Define ADDSUB_ARB_OVF_EN to also check the overflow output.

module tb_addsub_arbiter;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         req0, req1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         mode0, mode1;
   logic         ack0, ack1, done0, done1;
   logic [W-1:0] result;
   logic         carry;
   logic         busy;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   addsub_arbiter #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (req0),
      .req1     (req1),
      .a0       (a0),
      .b0       (b0),
      .a1       (a1),
      .b1       (b1),
      .mode0    (mode0),
      .mode1    (mode1),
      .ack0     (ack0),
      .ack1     (ack1),
      .done0    (done0),
      .done1    (done1),
      .result   (result),
      .carry    (carry),
`ifdef ADDSUB_ARB_OVF_EN
      .overflow (overflow),
`endif
      .busy     (busy)
   );

`ifndef ADDSUB_ARB_OVF_EN
   assign overflow = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         port;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         mode;
      logic [W-1:0] res;
      logic         cy;
      logic         ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] res;
      logic         cy;
      logic         ovf;
   } op_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Plain-integer reference for one operation.
   function automatic op_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic mode);
      op_t o;
      int ia, ib, sa, sb, s, sr;
      ia = int'(a);
      ib = int'(b);
      sa = (ia >= (1 << (W - 1))) ? ia - (1 << W) : ia;
      sb = (ib >= (1 << (W - 1))) ? ib - (1 << W) : ib;
      if (mode) begin
         s    = ia - ib;
         sr   = sa - sb;
         o.cy = (ia >= ib);
      end else begin
         s    = ia + ib;
         sr   = sa + sb;
         o.cy = (s >= (1 << W));
      end
      o.res = W'((s + (1 << W)) % (1 << W));
      o.ovf = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      return o;
   endfunction

   // One isolated transaction with full timing checks; optionally scribbles
   // over the operands right after ack to confirm they were latched.
   task automatic do_op(input vec_t v, input bit scribble);
      if (!v.port) begin
         a0 = v.a; b0 = v.b; mode0 = v.mode; req0 = 1'b1;
      end else begin
         a1 = v.a; b1 = v.b; mode1 = v.mode; req1 = 1'b1;
      end
      tick();
      chk("ack_own",   v.port ? ack1 : ack0, 1);
      chk("ack_other", v.port ? ack0 : ack1, 0);
      chk("busy_ack",  busy, 0);
      req0 = 1'b0;
      req1 = 1'b0;
      if (scribble) begin
         a0 = '0; b0 = '1; a1 = '0; b1 = '1; mode0 = ~mode0; mode1 = ~mode1;
      end
      tick();
      chk("ack_clear", ack0 | ack1, 0);
      chk("busy_exec", busy, 1);
      chk("done_early", done0 | done1, 0);
      tick();
      chk("done_own",   v.port ? done1 : done0, 1);
      chk("done_other", v.port ? done0 : done1, 0);
      chk("result",     result, v.res);
      chk("carry",      carry, v.cy);
`ifdef ADDSUB_ARB_OVF_EN
      chk("overflow",   overflow, v.ovf);
`endif
      chk("busy_resp",  busy, 1);
      tick();
      chk("done_clear", done0 | done1, 0);
      chk("busy_idle",  busy, 0);
      chk("result_hold", result, v.res);
   endtask

   vec_t vecs [10];

   // Random-phase model state
   int     since;
   logic   m_last;
   logic   m_owner;
   op_t    m_pend;
   op_t    m_vis;

   initial begin
      vecs[0] = '{1'b0, 8'd111, 8'd41,  1'b0, 8'd152, 1'b0, 1'b1};
      vecs[1] = '{1'b1, 8'd15,  8'd11,  1'b1, 8'd4,   1'b1, 1'b0};
      vecs[2] = '{1'b1, 8'd2,   8'd3,   1'b1, 8'd255, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'd100, 8'd100, 1'b0, 8'd200, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0};
      vecs[6] = '{1'b1, 8'd0,   8'd0,   1'b1, 8'd0,   1'b1, 1'b0};
      vecs[7] = '{1'b0, 8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 8'd0,   8'd1,   1'b1, 8'd255, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 8'd255, 8'd255, 1'b0, 8'd254, 1'b1, 1'b0};

      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; mode0 = 1'b0; mode1 = 1'b0;

      // Reset state
      do_reset();
      chk("rst_ack",    ack0 | ack1, 0);
      chk("rst_done",   done0 | done1, 0);
      chk("rst_result", result, 0);
      chk("rst_carry",  carry, 0);
      chk("rst_busy",   busy, 0);
      chk("rst_ovf",    overflow, 0);

      // Table of isolated operations
      for (int i = 0; i < 10; i++) do_op(vecs[i], (i % 2) == 1);

      // Contention straight after reset: requester 0 first, then 1.
      do_reset();
      a0 = 8'd3;   b0 = 8'd2;   mode0 = 1'b1; req0 = 1'b1;
      a1 = 8'd200; b1 = 8'd100; mode1 = 1'b0; req1 = 1'b1;
      tick();
      chk("cont_ack0", ack0, 1);
      chk("cont_ack1_n", ack1, 0);
      req0 = 1'b0;
      tick();
      chk("cont_quiet", ack0 | ack1 | done0 | done1, 0);
      tick();
      chk("cont_done0", done0, 1);
      chk("cont_res0",  result, 1);
      chk("cont_cy0",   carry, 1);
      tick();
      chk("cont_ack1", ack1, 1);
      chk("cont_done_clr", done0 | done1, 0);
      req1 = 1'b0;
      tick();
      tick();
      chk("cont_done1", done1, 1);
      chk("cont_res1",  result, 44);
      chk("cont_cy1",   carry, 1);
      tick();

      // Both requests held continuously: grants alternate every third edge.
      do_reset();
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("alt_ack0", ack0, ((k % 3) == 0 && ((k / 3) % 2) == 0) ? 1 : 0);
         chk("alt_ack1", ack1, ((k % 3) == 0 && ((k / 3) % 2) == 1) ? 1 : 0);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      // Reset during EXEC aborts the operation without a done.
      a0 = 8'd3; b0 = 8'd4; mode0 = 1'b0; req0 = 1'b1;
      tick();
      chk("abort_ack0", ack0, 1);
      req0 = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_result", result, 0);
      chk("abort_busy",   busy, 0);
      chk("abort_done_a", done0 | done1, 0);
      tick();
      chk("abort_done_b", done0 | done1, 0);
      tick();
      chk("abort_done_c", done0 | done1, 0);
      do_op(vecs[0], 1'b0);

      // Randomized traffic against a transaction-level model.
      do_reset();
      since  = 9;
      m_last = 1'b1;
      m_owner = 1'b0;
      m_pend = '{'0, 1'b0, 1'b0};
      m_vis  = '{'0, 1'b0, 1'b0};
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic e_ack0, e_ack1, e_done0, e_done1, e_busy, g;
         int   s;
         tick();
         e_ack0 = 1'b0; e_ack1 = 1'b0; e_done0 = 1'b0; e_done1 = 1'b0;
         s = (since >= 9) ? 9 : since + 1;
         if (s >= 3 && (req0 || req1)) begin
            g       = (req0 && req1) ? !m_last : req1;
            m_last  = g;
            m_owner = g;
            m_pend  = g ? ref_op(a1, b1, mode1) : ref_op(a0, b0, mode0);
            e_ack0  = !g;
            e_ack1  = g;
            since   = 0;
            e_busy  = 1'b0;
         end else begin
            since  = s;
            e_busy = (s == 1) || (s == 2);
            if (s == 2) begin
               e_done0 = !m_owner;
               e_done1 = m_owner;
               m_vis   = m_pend;
            end
         end
         chk("rnd_ack0",  ack0,  e_ack0);
         chk("rnd_ack1",  ack1,  e_ack1);
         chk("rnd_done0", done0, e_done0);
         chk("rnd_done1", done1, e_done1);
         chk("rnd_busy",  busy,  e_busy);
         if (s != 1) begin
            chk("rnd_result", result, m_vis.res);
            chk("rnd_carry",  carry,  m_vis.cy);
`ifdef ADDSUB_ARB_OVF_EN
            chk("rnd_ovf",    overflow, m_vis.ovf);
`endif
         end
         // Requester behaviour: drop (or occasionally keep) req after ack,
         // raise new requests at random, scramble operands freely.
         if (ack0)      req0 = ($urandom_range(3) == 0);
         else if (!req0) req0 = ($urandom_range(2) == 0);
         if (ack1)      req1 = ($urandom_range(3) == 0);
         else if (!req1) req1 = ($urandom_range(2) == 0);
         if ($urandom_range(1) == 1) begin
            a0 = W'($urandom); b0 = W'($urandom); mode0 = 1'($urandom);
         end
         if ($urandom_range(1) == 1) begin
            a1 = W'($urandom); b1 = W'($urandom); mode1 = 1'($urandom);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
